pc_seq: RTL and testbench

PC_SEQ -- requirements
Module: pc_seq

---
 rtl/pc_seq_pkg.sv | 20 ++
 rtl/pc_seq_if.sv | 45 ++++
 rtl/pc_reg.sv | 33 +++
 rtl/pc_seq.sv | 102 ++++++++++
 tb/tb_pc_seq.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg -- shared definitions for the program-counter sequencer.
//
// Holds the FSM state encoding and the default program-counter width.
// Imported by pc_seq_if, pc_reg and pc_seq.

package pc_seq_pkg;

    // Default program-counter width in bits.
    localparam int PC_SEQ_ADDR_W = 8;

    // FSM state encoding. 2'd3 is never entered on purpose; if it is
    // ever observed, the FSM falls back to ST_RST on the next edge.
    typedef enum logic [1:0] {
        ST_RST    = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2,
        ST_UNUSED = 2'd3
    } state_e;

endpackage

// File: rtl/pc_seq_if.sv
// pc_seq_if -- control and fetch-address bundle for pc_seq.
//
// Signals:
//   stall      controller -> seq  hold the current PC this cycle
//   jump       controller -> seq  load jump_addr into the PC this cycle
//   jump_addr  controller -> seq  jump target (ADDR_W bits)
//   halt       controller -> seq  enter HALTED (only with PC_SEQ_HALT_EN)
//   pc         seq -> controller  current fetch address
//   pc_valid   seq -> controller  pc is a live fetch address this cycle
//   state      seq -> controller  current FSM state encoding
//
// Handshake: there is no back-pressure. Controls are sampled at every
// rising clk edge; pc/pc_valid/state are registered and change only
// just after that edge. pc is meaningful to the consumer only while
// pc_valid=1.
//
// Optional feature macro: PC_SEQ_HALT_EN adds the halt signal.
// master = the controller driving the sequencer; slave = pc_seq.

interface pc_seq_if #(
    parameter int ADDR_W = pc_seq_pkg::PC_SEQ_ADDR_W
);
    logic              stall;
    logic              jump;
    logic [ADDR_W-1:0] jump_addr;
`ifdef PC_SEQ_HALT_EN
    logic              halt;
`endif
    logic [ADDR_W-1:0] pc;
    logic              pc_valid;
    logic [1:0]        state;

`ifdef PC_SEQ_HALT_EN
    modport master (output stall, jump, jump_addr, halt,
                    input  pc, pc_valid, state);
    modport slave  (input  stall, jump, jump_addr, halt,
                    output pc, pc_valid, state);
`else
    modport master (output stall, jump, jump_addr,
                    input  pc, pc_valid, state);
    modport slave  (input  stall, jump, jump_addr,
                    output pc, pc_valid, state);
`endif

endinterface

// File: rtl/pc_reg.sv
// pc_reg -- program-counter storage register.
//
// Ports:
//   clk      clock, rising edge
//   rst      synchronous active-high reset, loads RESET_VEC
//   load_en  when 1, q takes d at the next edge; otherwise q holds
//   d        next PC value
//   q        stored PC value

module pc_reg #(
    parameter int                ADDR_W    = pc_seq_pkg::PC_SEQ_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] d,
    output logic [ADDR_W-1:0] q
);

    logic [ADDR_W-1:0] pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_VEC;
        end else if (load_en) begin
            pc_q <= d;
        end
    end

    assign q = pc_q;

endmodule

// File: rtl/pc_seq.sv
// pc_seq -- program-counter sequencer with reset/run(/halt) FSM.
//
// Ports:
//   clk    clock, all state updates on the rising edge
//   reset  synchronous active-high reset (forces RST, pc=RESET_VEC)
//   bus    pc_seq_if.slave: stall/jump/jump_addr(/halt) in,
//          pc/pc_valid/state out (all outputs registered)
//
// After reset the FSM spends exactly one cycle in RST (pc=RESET_VEC,
// pc_valid=0), then enters RUN where the next PC is chosen by priority
// halt > jump > stall > increment (wrapping modulo 2^ADDR_W).
//
// Optional feature macro: PC_SEQ_HALT_EN adds the halt input and the
// HALTED state, which holds pc with pc_valid=0 until reset.

module pc_seq
    import pc_seq_pkg::*;
#(
    parameter int                ADDR_W    = PC_SEQ_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic     clk,
    input  logic     reset,
    pc_seq_if.slave  bus
);

    state_e            state_q;
    state_e            state_d;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_q;

    pc_reg #(
        .ADDR_W    (ADDR_W),
        .RESET_VEC (RESET_VEC)
    ) u_pc_reg (
        .clk     (clk),
        .rst     (reset),
        .load_en (pc_load),
        .d       (pc_d),
        .q       (pc_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_load = 1'b0;
        pc_d    = pc_q;

        case (state_q)
            ST_RST: begin
                // Re-load the reset vector so that recovery from the
                // unused encoding also restarts at RESET_VEC; the first
                // RUN cycle presents RESET_VEC itself, not RESET_VEC+1.
                state_d = ST_RUN;
                pc_load = 1'b1;
                pc_d    = RESET_VEC;
            end

            ST_RUN: begin
`ifdef PC_SEQ_HALT_EN
                if (bus.halt) begin
                    // pc is held; pc_valid drops because of the state.
                    state_d = ST_HALTED;
                end else
`endif
                if (bus.jump) begin
                    pc_load = 1'b1;
                    pc_d    = bus.jump_addr;
                end else if (!bus.stall) begin
                    pc_load = 1'b1;
                    pc_d    = ADDR_W'(pc_q + 1'b1);
                end
            end

`ifdef PC_SEQ_HALT_EN
            ST_HALTED: begin
                // Only reset leaves HALTED; controls are ignored.
                state_d = ST_HALTED;
            end
`endif

            default: begin
                state_d = ST_RST;
            end
        endcase
    end

    // Outputs come straight from flops (state_q, pc_q); no input reaches
    // them without passing through a register.
    assign bus.pc       = pc_q;
    assign bus.pc_valid = (state_q == ST_RUN);
    assign bus.state    = state_q;

endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq -- self-checking bench for pc_seq (ADDR_W=8, RESET_VEC=8'h10).
//
// A cycle-level model of the sequencer's rules produces the expected
// {state, pc_valid, pc} for every edge into exp_q; a compare process pops
// and checks on every falling edge. Directed steps additionally pin
// hand-computed literal values. Halt scenarios run only when
// PC_SEQ_HALT_EN is defined.

module tb_pc_seq;

    localparam int         AW  = 8;
    localparam logic [7:0] RV  = 8'h10;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    // {state[1:0], pc_valid, pc[7:0]}
    logic [10:0] exp_q[$];

    pc_seq_if #(.ADDR_W(AW)) bus ();

    pc_seq #(
        .ADDR_W    (AW),
        .RESET_VEC (RV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: run did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- model ----------------
    // mode: 0 = reset cycle, 1 = running, 2 = halted
    int         m_mode = 0;
    logic [7:0] m_pc   = RV;

    always @(posedge clk) begin
        int         n_mode;
        int         n_pc;
        logic       h;
        logic [1:0] st;
        h = 1'b0;
`ifdef PC_SEQ_HALT_EN
        h = bus.halt;
`endif
        n_mode = m_mode;
        n_pc   = int'(m_pc);
        if (reset) begin
            n_mode = 0;
            n_pc   = int'(RV);
        end else if (m_mode == 0) begin
            n_mode = 1;
            n_pc   = int'(RV);
        end else if (m_mode == 1) begin
            if (h)                n_mode = 2;
            else if (bus.jump)    n_pc   = int'(bus.jump_addr);
            else if (!bus.stall)  n_pc   = (n_pc + 1) % 256;
        end
        m_mode <= n_mode;
        m_pc   <= n_pc[7:0];
        st = n_mode[1:0];
        exp_q.push_back({st, (n_mode == 1), n_pc[7:0]});
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic [10:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if ({bus.state, bus.pc_valid, bus.pc} !== e) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t: got state=%0d valid=%0b pc=%02h, required state=%0d valid=%0b pc=%02h",
                         $time, bus.state, bus.pc_valid, bus.pc, e[10:9], e[8], e[7:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic j, input logic [7:0] a, input logic h);
        bus.stall     = s;
        bus.jump      = j;
        bus.jump_addr = a;
`ifdef PC_SEQ_HALT_EN
        bus.halt      = h;
`else
        if (h) $display("note: halt requested without PC_SEQ_HALT_EN");
`endif
    endtask

    task automatic check_lit(input string name, input logic [1:0] st,
                             input logic v, input logic [7:0] p);
        n_tests++;
        if (bus.state !== st || bus.pc_valid !== v || bus.pc !== p) begin
            n_fail++;
            $display("FAIL %s: got state=%0d valid=%0b pc=%02h, required state=%0d valid=%0b pc=%02h",
                     name, bus.state, bus.pc_valid, bus.pc, st, v, p);
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        reset = 1'b1;

        // Reset for two cycles, release: one RST cycle, then 10,11,12.
        cyc();
        cyc();
        check_lit("reset_hold", 2'd0, 1'b0, 8'h10);
        reset = 1'b0;
        cyc();
        check_lit("first_run", 2'd1, 1'b1, 8'h10);
        cyc();
        check_lit("inc_11", 2'd1, 1'b1, 8'h11);
        cyc();
        check_lit("inc_12", 2'd1, 1'b1, 8'h12);

        // Stall three cycles at 12, then resume at 13.
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check_lit("stall_hold", 2'd1, 1'b1, 8'h12);
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        cyc();
        check_lit("stall_resume", 2'd1, 1'b1, 8'h13);

        // Jump wins over stall.
        drive(1'b1, 1'b1, 8'hA0, 1'b0);
        cyc();
        check_lit("jump_over_stall", 2'd1, 1'b1, 8'hA0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        cyc();
        check_lit("after_jump", 2'd1, 1'b1, 8'hA1);

        // Wrap-around from FE.
        drive(1'b0, 1'b1, 8'hFE, 1'b0);
        cyc();
        check_lit("wrap_fe", 2'd1, 1'b1, 8'hFE);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        cyc();
        check_lit("wrap_ff", 2'd1, 1'b1, 8'hFF);
        cyc();
        check_lit("wrap_00", 2'd1, 1'b1, 8'h00);
        cyc();
        check_lit("wrap_01", 2'd1, 1'b1, 8'h01);

        // One-cycle reset pulse mid-run at 40.
        drive(1'b0, 1'b1, 8'h40, 1'b0);
        cyc();
        check_lit("jump_40", 2'd1, 1'b1, 8'h40);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        reset = 1'b1;
        cyc();
        check_lit("midrun_reset", 2'd0, 1'b0, 8'h10);
        reset = 1'b0;
        cyc();
        check_lit("midrun_rerun", 2'd1, 1'b1, 8'h10);
        cyc();
        check_lit("midrun_inc", 2'd1, 1'b1, 8'h11);

        // Reset overrides a simultaneous jump; RST ignores controls.
        drive(1'b0, 1'b1, 8'h77, 1'b0);
        reset = 1'b1;
        cyc();
        check_lit("reset_over_jump", 2'd0, 1'b0, 8'h10);
        reset = 1'b0;
        cyc();
        check_lit("rst_ignores_jump", 2'd1, 1'b1, 8'h10);
        cyc();
        check_lit("run_jump_77", 2'd1, 1'b1, 8'h77);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        cyc();
        check_lit("inc_78", 2'd1, 1'b1, 8'h78);

`ifdef PC_SEQ_HALT_EN
        // Halt wins over jump at 05 and holds until reset.
        drive(1'b0, 1'b1, 8'h05, 1'b0);
        cyc();
        check_lit("jump_05", 2'd1, 1'b1, 8'h05);
        drive(1'b0, 1'b1, 8'h33, 1'b1);
        cyc();
        check_lit("halt_enter", 2'd2, 1'b0, 8'h05);
        drive(1'b1, 1'b1, 8'h99, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cyc();
            check_lit("halt_hold", 2'd2, 1'b0, 8'h05);
        end
        reset = 1'b1;
        cyc();
        check_lit("halt_reset", 2'd0, 1'b0, 8'h10);
        reset = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        cyc();
        check_lit("halt_rerun", 2'd1, 1'b1, 8'h10);
`endif

        // Let the compare process consume the last expectation.
        @(negedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
